// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous-read RAM.
// One access in flight at a time; ties are broken by a toggling priority pointer.
module ram_port_arbiter #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // The RAM must fit in the address space the ports can express.
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH exceeds ADDR_WIDTH address space");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  id_q, id_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  win;

    // Next-state: arbitrate in IDLE, capture the read result at the end of WAIT.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win     = (req0 && req1) ? prio_q : req1;
                    id_d    = win;
                    we_d    = win ? we1 : we0;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    prio_d  = ~win;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = we_q ? IDLE : WAIT;
            WAIT: begin
                if (id_q) rdata1_d = ram_dout;
                else      rdata0_d = ram_dout;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and command registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decode only from registered state; ram_we is also killed by rst.
    always_comb begin
        ram_addr = addr_q;
        ram_din  = wdata_q;
        ram_we   = (state_q == ISSUE) && we_q && !rst;
        gnt0     = (state_q == ISSUE) && !id_q;
        gnt1     = (state_q == ISSUE) && id_q;
        rvalid0  = (state_q == RESP) && !id_q;
        rvalid1  = (state_q == RESP) && id_q;
        rdata0   = rdata0_q;
        rdata1   = rdata1_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed stimulus,
// expected grant/response events queued and checked by a monitor.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout = '0;

    ram_port_arbiter #(.DEPTH(4096), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Single-port RAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rv;
        bit          id;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic mon_check(input bit rv, input bit id, input logic both,
                             input logic [31:0] d);
        exp_t e;
        n_cmp++;
        if (both !== 1'b0) begin
            n_err++;
            $display("FAIL %s_both cyc=%0d: both requesters active together",
                     rv ? "rvalid" : "gnt", cyc);
        end else if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s cyc=%0d id=%0d data=%h, none expected",
                     rv ? "rvalid" : "gnt", cyc, id, d);
        end else begin
            e = sb.pop_front();
            if (e.rv != rv || e.id != id || e.cyc != cyc ||
                (rv && e.data !== d)) begin
                n_err++;
                $display("FAIL event: got %s id=%0d cyc=%0d data=%h, expected %s id=%0d cyc=%0d data=%h",
                         rv ? "rvalid" : "gnt", id, cyc, d,
                         e.rv ? "rvalid" : "gnt", e.id, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: every grant or response the DUT shows must match the queue head.
    always @(negedge clk) begin
        if (gnt0 === 1'b1 || gnt1 === 1'b1)
            mon_check(1'b0, gnt1 === 1'b1, gnt0 & gnt1, 32'h0);
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1)
            mon_check(1'b1, rvalid1 === 1'b1, rvalid0 & rvalid1,
                      (rvalid1 === 1'b1) ? rdata1 : rdata0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit id, input logic r, input logic w,
                         input logic [11:0] a, input logic [31:0] d);
        if (id) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Present one request, queue its grant (and response), wait for the grant.
    task automatic issue(input bit id, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input bit exp_rv,
                         input logic [31:0] exp_d, output int e);
        bit got;
        @(negedge clk);
        e = cyc + 1;
        sb.push_back('{rv: 1'b0, id: id, cyc: e, data: 32'h0});
        if (exp_rv) sb.push_back('{rv: 1'b1, id: id, cyc: e + 2, data: exp_d});
        drive(id, 1'b1, w, a, d);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if ((id ? gnt1 : gnt0) === 1'b1) got = 1'b1;
        end
        drive(id, 1'b0, 1'b0, a, d);
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL gnt_timeout id=%0d addr=%h: got no grant, expected one", id, a);
        end
    endtask

    task automatic access(input bit id, input logic w, input logic [11:0] a,
                          input logic [31:0] d);
        int e;
        issue(id, w, a, d, !w, d, e);
        if (!w) repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        bit ok;

        // Reset state
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt0", {31'b0, gnt0}, 32'h0);
        chk("rst_gnt1", {31'b0, gnt1}, 32'h0);
        chk("rst_rvalid0", {31'b0, rvalid0}, 32'h0);
        chk("rst_rvalid1", {31'b0, rvalid1}, 32'h0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst_ram_addr", {20'b0, ram_addr}, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        rst = 1'b0;

        // Write then read the top address from requester 0
        access(1'b0, 1'b1, 12'd4095, 32'd123456789);
        access(1'b0, 1'b0, 12'd4095, 32'd123456789);

        // Requester 1 alone, back-to-back writes
        for (int i = 0; i < 4; i++)
            access(1'b1, 1'b1, 12'(20 + i), 32'hA000_0000 + i);
        access(1'b1, 1'b0, 12'd22, 32'hA000_0002);

        // Both requesters hold write requests: grants alternate 0,1,0,1
        do_reset();
        @(negedge clk);
        e = cyc + 1;
        sb.push_back('{rv: 1'b0, id: 1'b0, cyc: e,     data: 32'h0});
        sb.push_back('{rv: 1'b0, id: 1'b1, cyc: e + 2, data: 32'h0});
        sb.push_back('{rv: 1'b0, id: 1'b0, cyc: e + 4, data: 32'h0});
        sb.push_back('{rv: 1'b0, id: 1'b1, cyc: e + 6, data: 32'h0});
        drive(1'b0, 1'b1, 1'b1, 12'd10, 32'h1111_0000);
        drive(1'b1, 1'b1, 1'b1, 12'd11, 32'h2222_0000);
        for (int i = 0; i < 40 && cyc < e + 6; i++) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 12'd10, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 12'd11, 32'h0);
        access(1'b1, 1'b0, 12'd11, 32'h2222_0000);
        access(1'b0, 1'b0, 12'd10, 32'h1111_0000);

        // Same-cycle read (req0) and write (req1) to addr 0, prio 0
        do_reset();
        @(negedge clk);
        e = cyc + 1;
        sb.push_back('{rv: 1'b0, id: 1'b0, cyc: e,     data: 32'h0});
        sb.push_back('{rv: 1'b1, id: 1'b0, cyc: e + 2, data: 32'h0});
        sb.push_back('{rv: 1'b0, id: 1'b1, cyc: e + 4, data: 32'h0});
        drive(1'b0, 1'b1, 1'b0, 12'd0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 12'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 32'h0);
        for (int i = 0; i < 40 && cyc < e + 4; i++) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 12'd0, 32'h0);
        chk("rdata0_before_write", rdata0, 32'h0);
        access(1'b0, 1'b0, 12'd0, 32'hDEAD_BEEF);

        // Reset during a read's WAIT: no response follows
        issue(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0, e);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rvalid0", {31'b0, rvalid0}, 32'h0);
        repeat (3) @(negedge clk);
        chk("abort_rdata0", rdata0, 32'h0);

        // Reset during a write's ISSUE: RAM keeps its old value
        issue(1'b0, 1'b1, 12'd0, 32'h1234_5678, 1'b0, 32'h0, e);
        rst = 1'b1;
        #1;
        chk("suppressed_ram_we", {31'b0, ram_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b0, 12'd0, 32'hDEAD_BEEF);

        // All-ones at both ends of the address range, neighbours untouched
        access(1'b0, 1'b1, 12'd0, 32'hFFFF_FFFF);
        access(1'b1, 1'b1, 12'd4095, 32'hFFFF_FFFF);
        access(1'b0, 1'b0, 12'd1, 32'h0);
        access(1'b1, 1'b0, 12'd4094, 32'h0);
        access(1'b0, 1'b0, 12'd0, 32'hFFFF_FFFF);
        access(1'b1, 1'b0, 12'd4095, 32'hFFFF_FFFF);
        chk("rdata0_hold", rdata0, 32'hFFFF_FFFF);
        access(1'b0, 1'b1, 12'd5, 32'h5555_5555);
        repeat (3) @(negedge clk);
        chk("rdata1_hold", rdata1, 32'hFFFF_FFFF);

        // Every queued event must have been seen
        repeat (4) @(negedge clk);
        ok = (sb.size() == 0);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL sb_drain: got %0d events outstanding, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 4096, SHALL set the word count of the attached single-port RAM.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the width of all address ports.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports.
REQ-004 clk  in  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 req0, req1  in  1 each  SHALL be the access requests; each is held with its payload until the matching grant.
REQ-007 we0, we1  in  1 each  SHALL select the access type: 1 = write, 0 = read.
REQ-008 addr0, addr1  in  ADDR_WIDTH each  SHALL be the requester word addresses.
REQ-009 wdata0, wdata1  in  DATA_WIDTH each  SHALL be the requester write data.
REQ-010 gnt0, gnt1  out  1 each  SHALL pulse for one cycle when that requester's access is issued to the RAM.
REQ-011 rvalid0, rvalid1  out  1 each  SHALL pulse for one cycle when rdata0 or rdata1 holds that requester's read result.
REQ-012 rdata0, rdata1  out  DATA_WIDTH each  SHALL be the read results.
REQ-013 ram_addr  out  ADDR_WIDTH  SHALL drive the RAM address.
REQ-014 ram_din  out  DATA_WIDTH  SHALL drive the RAM write data.
REQ-015 ram_we  out  1  SHALL drive the RAM write enable.
REQ-016 ram_dout  in  DATA_WIDTH  SHALL be the RAM read data, valid the cycle after the address is presented (synchronous read).

Function
REQ-017 The FSM SHALL have four states (IDLE, ISSUE, WAIT, RESP) and SHALL keep at most one RAM access outstanding.
REQ-018 In IDLE with no req, the FSM SHALL stay in IDLE.
REQ-019 In IDLE with any req, the FSM SHALL do the following, then go to ISSUE:
- pick the winner: the sole requester, or, if both request, the one named by priority pointer prio;
- latch the winner's id, we, addr and wdata into command registers;
- set prio to the non-winner.
REQ-020 In ISSUE:
- ram_addr and ram_din SHALL come from the command registers;
- ram_we SHALL equal the latched we, gated by ~rst;
- gnt<id> SHALL be 1;
- a write SHALL go next to IDLE;
- a read SHALL go next to WAIT.
REQ-021 In WAIT, ram_we SHALL be 0 and ram_addr SHALL hold; at the end of WAIT, ram_dout SHALL be registered into rdata<id>; next state RESP.
REQ-022 In RESP, rvalid<id> SHALL be 1; next state IDLE.
REQ-023 Latency, with req sampled in IDLE in cycle T:
- gnt in T+1;
- a write commits at the end of T+1, and the next request is sampled in T+2;
- a read gives rvalid plus data in T+3, and the next request is sampled in T+4.
REQ-024 RAM-side outputs and gnt/rvalid SHALL be decoded only from the state and command registers; there SHALL be no combinational path from req/addr/we/wdata to any output.
REQ-025 ram_we SHALL be 0 in every state other than ISSUE-with-write.
REQ-026 rdata0/rdata1 SHALL hold their last value until the next read response for that requester.
REQ-027 A requester whose req is still high at the edge ending its gnt cycle SHALL be treated as a new request.
REQ-028 With only one requester active, it SHALL be served back-to-back, with no idle slots reserved for the other.
REQ-029 gnt0 and gnt1 SHALL never be high together; the same SHALL hold for rvalid0 and rvalid1.

Reset
REQ-030 While rst is high at a rising edge, the block SHALL set:
- state to IDLE and prio to 0;
- gnt0, gnt1, rvalid0, rvalid1 and ram_we to 0;
- ram_addr, ram_din, rdata0 and rdata1 to 0.
REQ-031 rst asserted in ISSUE SHALL suppress the write (ram_we = 0 that cycle), leaving the RAM unchanged.
REQ-032 rst asserted in WAIT or RESP SHALL abort the read, with no rvalid afterwards.
REQ-033 After rst deasserts, the first request SHALL be sampled in the next IDLE cycle.

Verification
REQ-034 req0 write 123456789 to addr 4095, then req0 read 4095 -> gnt0 one cycle after each request; rvalid0 three cycles after the read request; rdata0 = 123456789.
REQ-035 After reset, req0 and req1 both write -> gnt0 in T+1 and gnt1 in T+3; both then held continuously -> grants alternate 0,1,0,1 thereafter.
REQ-036 req1 alone issues 4 consecutive writes -> gnt1 every 2 cycles; gnt0 and rvalid0 stay 0.
REQ-037 Addr 0 holds 0x00000000, prio = 0; req0 reads addr 0 while req1 writes 0xDEADBEEF to addr 0 in the same cycle -> rdata0 = 0x00000000; a later read of addr 0 returns 0xDEADBEEF.
REQ-038 rst pulsed during a read's WAIT -> no rvalid; state IDLE. rst pulsed during a write's ISSUE to addr 0 -> a later read of addr 0 returns its previous value.
REQ-039 Write 0xFFFFFFFF to addr 0 and addr 4095, then read both -> 0xFFFFFFFF each; no aliasing onto neighbouring addresses 1 and 4094.
